// File: rtl/sat_pkg.sv
// Shared types and constants for the saturating arithmetic controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sat_pkg;

    // Controller sequencing states; the encoding is fixed so other blocks can decode it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Clamp values for the four overflow directions.
    localparam logic [7:0] SAT_U_MAX = 8'hFF;
    localparam logic [7:0] SAT_U_MIN = 8'h00;
    localparam logic [7:0] SAT_S_MAX = 8'h7F;
    localparam logic [7:0] SAT_S_MIN = 8'h80;

    // Operation captured at acceptance; A already resolved to operand or accumulator.
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       sgn;
        logic       acc;
    } op_t;

endpackage

// File: rtl/sat_unit.sv
// Saturation clamp: replaces the raw sum with the limit selected by sign and mode.
// Latency: combinational, zero cycles.
// Backpressure: none; a pure function of its inputs.
module sat_unit
    import sat_pkg::*;
(
    input  logic [7:0] i_raw,
    input  logic       i_sat_enable,
    input  logic       i_sat_last,
    input  logic       i_sat_sign,
    output logic [7:0] o_result
);

    // sat_last picks the signed limits; sat_sign picks the negative/underflow side.
    always_comb begin
        o_result = i_raw;
        if (i_sat_enable) begin
            if (i_sat_last) begin
                o_result = i_sat_sign ? SAT_S_MIN : SAT_S_MAX;
            end else begin
                o_result = i_sat_sign ? SAT_U_MIN : SAT_U_MAX;
            end
        end
    end

endmodule

// File: rtl/sat_ctrl.sv
// Saturating 8-bit add/sub controller with optional accumulator and clamp statistics.
// Latency: accepted at edge N, result valid after edge N+1 (seen at N+2); one op per 3 cycles.
// Backpressure: in_ready low outside IDLE; result held in DONE until out_ready.
module sat_ctrl
    import sat_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       op_a,
    input  logic [7:0]       op_b,
    input  logic             op_sub,
    input  logic             op_signed,
    input  logic             acc_mode,
    input  logic             clear_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       result,
    output logic             sat_flag,
    output logic             sat_sticky,
    output logic [CNT_W-1:0] sat_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_next;
    op_t              r_op;
    logic [7:0]       r_acc;
    logic [7:0]       r_result;
    logic             r_sat_flag;
    logic             r_sticky;
    logic [CNT_W-1:0] r_count;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_commit;
    logic             w_clear;
    logic [7:0]       w_a_sel;
    logic [8:0]       w_raw;
    logic             w_ovf_u;
    logic             w_ovf_s;
    logic             w_ovf;
    logic             w_sat_sign;
    logic [7:0]       w_sat_result;

    // State register; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_CALC;
                end
            end
            ST_CALC: begin
                w_commit = 1'b1;
                w_next   = ST_DONE;
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // in_ready is masked by reset so it stays low while rst_n is held.
    assign in_ready  = w_in_ready & rst_n;
    assign out_valid = w_out_valid;

    // clear_acc only has effect while idle; a same-cycle accumulate then sees A=0.
    assign w_clear = (r_state == ST_IDLE) & clear_acc;
    assign w_a_sel = acc_mode ? (w_clear ? 8'h00 : r_acc) : op_a;

    // Capture operands and mode bits on acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op <= '0;
        end else if (w_accept) begin
            r_op.a   <= w_a_sel;
            r_op.b   <= op_b;
            r_op.sub <= op_sub;
            r_op.sgn <= op_signed;
            r_op.acc <= acc_mode;
        end
    end

    // 9-bit raw result from zero-extended operands; bit 8 is carry or borrow.
    assign w_raw = r_op.sub ? ({1'b0, r_op.a} - {1'b0, r_op.b})
                            : ({1'b0, r_op.a} + {1'b0, r_op.b});

    // Signed overflow: operands agree in effective sign but the result flips away from it.
    assign w_ovf_u    = w_raw[8];
    assign w_ovf_s    = (r_op.a[7] == (r_op.b[7] ^ r_op.sub)) && (w_raw[7] != r_op.a[7]);
    assign w_ovf      = r_op.sgn ? w_ovf_s : w_ovf_u;
    assign w_sat_sign = r_op.sgn ? r_op.a[7] : r_op.sub;

    sat_unit u_sat (
        .i_raw        (w_raw[7:0]),
        .i_sat_enable (w_ovf),
        .i_sat_last   (r_op.sgn),
        .i_sat_sign   (w_sat_sign),
        .o_result     (w_sat_result)
    );

    // Result beat registers: loaded on CALC->DONE, held through DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result   <= 8'h00;
            r_sat_flag <= 1'b0;
        end else if (w_commit) begin
            r_result   <= w_sat_result;
            r_sat_flag <= w_ovf;
        end
    end

    // Accumulator: cleared in IDLE on request, written back on commit in accumulate mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= 8'h00;
        end else if (w_clear) begin
            r_acc <= 8'h00;
        end else if (w_commit && r_op.acc) begin
            r_acc <= w_sat_result;
        end
    end

    // Clamp statistics: sticky is clearable, the counter only resets and never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_clear) begin
                r_sticky <= 1'b0;
            end else if (w_commit && w_ovf) begin
                r_sticky <= 1'b1;
            end
            if (w_commit && w_ovf && (r_count != CNT_MAX)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign result     = r_result;
    assign sat_flag   = r_sat_flag;
    assign sat_sticky = r_sticky;
    assign sat_count  = r_count;

endmodule

// File: tb/tb_sat_ctrl.sv
// Testbench for sat_ctrl: directed corner cases then random ops against a reference model.
// Latency: checks acceptance at N and out_valid seen at N+2.
// Backpressure: exercises out_ready stalls with ignored in_valid/clear_acc.
module tb_sat_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_sub;
    logic       op_signed;
    logic       acc_mode;
    logic       clear_acc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       sat_flag;
    logic       sat_sticky;
    logic [7:0] sat_count;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state.
    int m_acc;
    int m_sticky;
    int m_count;
    int m_res;
    int m_flag;

    sat_ctrl #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_sub     (op_sub),
        .op_signed  (op_signed),
        .acc_mode   (acc_mode),
        .clear_acc  (clear_acc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .sat_flag   (sat_flag),
        .sat_sticky (sat_sticky),
        .sat_count  (sat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Mathematical saturating arithmetic: compute exact result, clamp to the range.
    task automatic model_op(input int a, input int b, input bit sub, input bit sgn,
                            output int res, output int flag);
        int r;
        int lo;
        int hi;
        if (sgn) begin
            if (a > 127) a = a - 256;
            if (b > 127) b = b - 256;
            lo = -128;
            hi = 127;
        end else begin
            lo = 0;
            hi = 255;
        end
        r    = sub ? (a - b) : (a + b);
        flag = 0;
        if (r > hi) begin
            r    = hi;
            flag = 1;
        end else if (r < lo) begin
            r    = lo;
            flag = 1;
        end
        res = r & 255;
    endtask

    // One full transaction from IDLE back to IDLE; exp_res/exp_flg < 0 means no fixed target.
    task automatic run_op(input int a, input int b, input bit sub, input bit sgn,
                          input bit acc, input bit clr, input int hold,
                          input int exp_res, input int exp_flg);
        int eff_a;
        if (clr) begin
            m_acc    = 0;
            m_sticky = 0;
        end
        eff_a = acc ? m_acc : a;
        model_op(eff_a, b, sub, sgn, m_res, m_flag);
        if (m_flag != 0) begin
            m_sticky = 1;
            if (m_count < 255) m_count++;
        end
        if (acc) m_acc = m_res;

        chk("rdy_idle", int'(in_ready), 1);
        in_valid  = 1'b1;
        op_a      = 8'(a);
        op_b      = 8'(b);
        op_sub    = sub;
        op_signed = sgn;
        acc_mode  = acc;
        clear_acc = clr;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rdy_calc", int'(in_ready), 0);
        chk("vld_calc", int'(out_valid), 0);
        in_valid  = 1'($urandom_range(0, 1));
        clear_acc = 1'($urandom_range(0, 1));
        op_a      = 8'($urandom);
        op_b      = 8'($urandom);
        acc_mode  = 1'($urandom_range(0, 1));
        out_ready = (hold == 0);
        @(negedge clk);
        chk("vld_done", int'(out_valid), 1);
        chk("result", int'(result), m_res);
        chk("sat_flag", int'(sat_flag), m_flag);
        chk("sticky", int'(sat_sticky), m_sticky);
        chk("count", int'(sat_count), m_count);
        if (exp_res >= 0) chk("dir_result", int'(result), exp_res);
        if (exp_flg >= 0) chk("dir_flag", int'(sat_flag), exp_flg);
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;
            clear_acc = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("stall_vld", int'(out_valid), 1);
            chk("stall_rdy", int'(in_ready), 0);
            chk("stall_res", int'(result), m_res);
            chk("stall_flag", int'(sat_flag), m_flag);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        clear_acc = 1'b0;
        @(negedge clk);
        chk("vld_after", int'(out_valid), 0);
        chk("rdy_after", int'(in_ready), 1);
        out_ready = 1'b0;
        acc_mode  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = 8'h00;
        op_b      = 8'h00;
        op_sub    = 1'b0;
        op_signed = 1'b0;
        acc_mode  = 1'b0;
        clear_acc = 1'b0;
        out_ready = 1'b0;
        m_acc = 0; m_sticky = 0; m_count = 0; m_res = 0; m_flag = 0;

        repeat (2) @(negedge clk);
        chk("rst_rdy", int'(in_ready), 0);
        chk("rst_vld", int'(out_valid), 0);
        chk("rst_res", int'(result), 0);
        chk("rst_flag", int'(sat_flag), 0);
        chk("rst_sticky", int'(sat_sticky), 0);
        chk("rst_count", int'(sat_count), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", int'(in_ready), 1);

        // Unsigned add overflow with out_ready present at DONE entry.
        run_op(8'hF0, 8'h20, 0, 0, 0, 0, 0, 8'hFF, 1);
        chk("count_one", int'(sat_count), 1);
        // Unsigned borrow, then a clean subtract keeping sticky.
        run_op(8'h10, 8'h20, 1, 0, 0, 0, 1, 8'h00, 1);
        run_op(8'h20, 8'h10, 1, 0, 0, 0, 0, 8'h10, 0);
        chk("sticky_kept", int'(sat_sticky), 1);
        // Signed cases.
        run_op(8'h70, 8'h20, 0, 1, 0, 0, 0, 8'h7F, 1);
        run_op(8'h80, 8'h01, 1, 1, 0, 0, 0, 8'h80, 1);
        run_op(8'hFF, 8'h01, 0, 1, 0, 0, 0, 8'h00, 0);
        // Accumulate chain starting from a clear.
        run_op(8'h00, 8'h60, 0, 1, 1, 1, 0, 8'h60, 0);
        run_op(8'h00, 8'h60, 0, 1, 1, 0, 0, 8'h7F, 1);
        run_op(8'h00, 8'h60, 0, 1, 1, 0, 0, 8'h7F, 1);
        // Accumulator readback through an add of zero.
        run_op(8'h00, 8'h00, 0, 0, 1, 0, 0, 8'h7F, 0);
        // Long stall in DONE.
        run_op(8'h33, 8'h44, 0, 0, 0, 0, 5, 8'h77, 0);

        // Reset while in CALC discards the operation and the accumulator.
        in_valid  = 1'b1;
        acc_mode  = 1'b1;
        op_b      = 8'h01;
        op_sub    = 1'b0;
        op_signed = 1'b0;
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        acc_mode = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rcalc_vld", int'(out_valid), 0);
        chk("rcalc_res", int'(result), 0);
        chk("rcalc_sticky", int'(sat_sticky), 0);
        chk("rcalc_count", int'(sat_count), 0);
        rst_n = 1'b1;
        out_ready = 1'b0;
        m_acc = 0; m_sticky = 0; m_count = 0;
        @(negedge clk);
        chk("rcalc_nobeat", int'(out_valid), 0);
        run_op(8'h00, 8'h05, 0, 0, 1, 0, 0, 8'h05, 0);

        // Random traffic against the model.
        for (int k = 0; k < 200; k++) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                   int'($urandom_range(0, 3)), -1, -1);
        end

        // Drive the counter past its maximum; it must hold at all-ones.
        for (int k = 0; k < 260; k++) begin
            run_op(8'hFF, 8'hFF, 0, 0, 0, 0, 0, -1, 1);
        end
        chk("count_hold", int'(sat_count), 255);
        // clear_acc leaves the counter alone.
        run_op(8'h01, 8'h01, 0, 0, 0, 1, 0, 8'h02, 0);
        chk("count_after_clr", int'(sat_count), 255);
        chk("sticky_after_clr", int'(sat_sticky), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/sat_ctrl.md
SAT_CTRL -- requirements
Module: sat_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the saturation-event counter.
REQ-002 SHALL have ports clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have ports in_valid (in, 1) and in_ready (out, 1): operation request handshake.
REQ-005 SHALL have ports op_a (in, 8) and op_b (in, 8): operands.
REQ-006 SHALL have port op_sub (in, 1): 1 = A-B, 0 = A+B.
REQ-007 SHALL have port op_signed (in, 1): 1 = two's-complement saturation, 0 = unsigned.
REQ-008 SHALL have port acc_mode (in, 1): 1 = use accumulator as A and write the result back to it.
REQ-009 SHALL have port clear_acc (in, 1): zeroes the accumulator and sat_sticky.
REQ-010 SHALL have ports out_valid (out, 1) and out_ready (in, 1): result handshake.
REQ-011 SHALL have port result (out, 8): saturated result, stable while out_valid=1.
REQ-012 SHALL have port sat_flag (out, 1): the current result was clamped.
REQ-013 SHALL have port sat_sticky (out, 1): a clamp has occurred since the last reset or clear.
REQ-014 SHALL have port sat_count (out, CNT_W): number of clamped operations.

Function
REQ-015 SHALL implement FSM states IDLE, CALC and DONE.
- IDLE: in_ready=1; in_valid -> CALC, latching operands and mode bits.
- CALC: one cycle -> DONE.
- DONE: out_valid=1; out_ready -> IDLE.
REQ-016 SHALL give latency from acceptance edge N to out_valid=1 at edge N+2; throughput is one operation per 3 cycles when out_ready=1.
REQ-017 SHALL hold in_ready=0 in CALC and DONE; in_valid in those states is ignored, not queued.
REQ-018 SHALL form a 9-bit raw result from the zero-extended operands in CALC.
REQ-019 SHALL detect overflow as follows:
- unsigned add: carry out.
- unsigned sub: borrow.
- signed: A[7] equals the effective B sign (B[7] XOR op_sub) and raw[7] differs from A[7].
REQ-020 SHALL drive the saturation unit as follows:
- sat_enable = overflow.
- sat_last = op_signed.
- sat_sign: unsigned = op_sub; signed = A[7].
REQ-021 SHALL clamp as follows:
- unsigned add overflow -> 0xFF; unsigned sub underflow -> 0x00.
- signed positive overflow -> 0x7F; signed negative overflow -> 0x80.
- no overflow -> raw[7:0].
REQ-022 SHALL register result and sat_flag at the CALC->DONE edge and hold them until leaving DONE.
REQ-023 SHALL, when acc_mode=1, write the saturated result into the accumulator at the CALC->DONE edge.
REQ-024 SHALL set sat_sticky and increment sat_count at the CALC->DONE edge when overflow=1.
REQ-025 SHALL hold sat_count at its all-ones value; it SHALL NOT wrap.
REQ-026 SHALL honour clear_acc only in IDLE.
- With simultaneous in_valid and acc_mode=1, the accepted operation uses A=0.
- clear_acc does not reset sat_count.
REQ-027 SHALL allow out_ready=1 arriving together with entry to DONE to complete the transaction on the following edge; out_valid is high for at least one cycle.

Reset
REQ-028 SHALL, while rst_n=0 at a rising edge, force:
- state IDLE.
- in_ready=0 during reset, 1 on the first cycle after reset.
- out_valid=0, result=0x00, sat_flag=0, sat_sticky=0, sat_count=0, accumulator=0x00.
REQ-029 SHALL, on reset in CALC or DONE, discard the in-flight operation without a result beat or accumulator update.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE=0, CALC=1, DONE=2) and the clamp constants 0xFF, 0x00, 0x7F and 0x80 in a shared package, sat_pkg.
REQ-031 SHALL instantiate exactly one existing saturation sub-module for clamping; the overflow detection and sequencing logic lives in sat_ctrl.

Verification
REQ-032 SHALL cover an unsigned add of 0xF0+0x20 with out_ready=1 -> result 0xFF, sat_flag=1, sat_count=1, out_valid at N+2.
REQ-033 SHALL cover an unsigned sub of 0x10-0x20 -> result 0x00 and sat_flag=1; a follow-up 0x20-0x10 -> result 0x10, sat_flag=0, sat_sticky still 1.
REQ-034 SHALL cover signed operations:
- 0x70+0x20 -> 0x7F.
- 0x80-0x01 -> 0x80.
- 0xFF+0x01 -> 0x00 with sat_flag=0.
REQ-035 SHALL cover accumulate mode: clear_acc together with acc_mode adds of 0x60, 0x60, 0x60 (signed) -> results 0x60, 0x7F, 0x7F and accumulator 0x7F.
REQ-036 SHALL cover out_ready held 0 for 5 cycles in DONE -> result stable, in_ready=0, a concurrent in_valid ignored; release -> IDLE next edge.
REQ-037 SHALL cover rst_n=0 asserted in CALC -> next cycle out_valid=0, accumulator 0x00, counters 0, no result beat.
